// File: rtl/regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wr_arbiter
//
// Purpose:
//   Shares the single synchronous write port of the register file among
//   NUM_REQ requesters. After reset the whole file is swept once, writing
//   zero to every entry. Write requests are then granted round-robin over a
//   valid/ready handshake. The register file write port is driven from
//   registered outputs, so an accepted request reaches the file one cycle
//   after its handshake.
//
// Ports:
//   clk          in   1            single clock, all logic on posedge
//   rst          in   1            synchronous reset, active-low (0 = reset)
//   req_valid    in   NUM_REQ      per-requester write request
//   req_addr     in   NUM_REQ*AW   packed, slice i = [i*AW +: AW]
//   req_data     in   NUM_REQ*DW   packed, slice i = [i*DW +: DW]
//   req_ready    out  NUM_REQ      one-hot-or-zero grant (combinational)
//   init_busy    out  1            high while the zero-sweep is running
//   rf_wr_enable out  1            register file write enable (registered)
//   rf_wr_addr   out  AW           register file write address (registered)
//   rf_wr_data   out  DW           register file write data (registered)
// ---------------------------------------------------------------------------
module regfile_wr_arbiter #(
  parameter int NUM_REQ          = 2,
  parameter int NUM_OF_SETS      = 32,
  parameter int DATA_BUS_WIDTH   = 32,
  parameter int ZERO_REG_PROTECT = 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_REQ-1:0]                       req_valid,
  input  logic [NUM_REQ*$clog2(NUM_OF_SETS)-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_BUS_WIDTH-1:0]        req_data,
  output logic [NUM_REQ-1:0]                       req_ready,
  output logic                                     init_busy,
  output logic                                     rf_wr_enable,
  output logic [$clog2(NUM_OF_SETS)-1:0]           rf_wr_addr,
  output logic [DATA_BUS_WIDTH-1:0]                rf_wr_data
);

  localparam int AW = $clog2(NUM_OF_SETS);
  localparam int DW = DATA_BUS_WIDTH;
  localparam int GW = $clog2(NUM_REQ);

  localparam logic [AW-1:0] LAST_SET  = AW'(NUM_OF_SETS - 1);
  localparam logic [GW-1:0] LAST_REQ  = GW'(NUM_REQ - 1);
  localparam bit            PROTECT_0 = (ZERO_REG_PROTECT != 0);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t          state_reg,      state_next;
  logic [AW-1:0]   sweep_cnt_reg,  sweep_cnt_next;
  logic [GW-1:0]   last_grant_reg, last_grant_next;
  logic            wr_enable_reg,  wr_enable_next;
  logic [AW-1:0]   wr_addr_reg,    wr_addr_next;
  logic [DW-1:0]   wr_data_reg,    wr_data_next;

  // -------------------------------------------------------------------------
  // Unpack the requester buses into per-requester arrays
  // -------------------------------------------------------------------------
  logic [AW-1:0] addr_arr [NUM_REQ];
  logic [DW-1:0] data_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*AW +: AW];
      assign data_arr[gi] = req_data[gi*DW +: DW];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Round-robin winner search: starts one past the last granted requester
  // and wraps, so the most recently served requester has lowest priority.
  // -------------------------------------------------------------------------
  logic          grant_found;
  logic [GW-1:0] grant_idx;
  logic [GW-1:0] probe_idx;
  int            probe_pos;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    probe_idx   = '0;
    probe_pos   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      probe_pos = (int'(last_grant_reg) + k) % NUM_REQ;
      probe_idx = GW'(probe_pos);
      if (!grant_found && req_valid[probe_idx]) begin
        grant_found = 1'b1;
        grant_idx   = probe_idx;
      end
    end
  end

  // A grant is only offered once the sweep is over; ready implies valid, so
  // a raised ready bit is itself the transfer.
  logic grant_active;
  assign grant_active = (state_reg == ST_ARB) && grant_found;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = grant_active && (grant_idx == GW'(gi));
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Next-state and output-register logic
  // -------------------------------------------------------------------------
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_data;

  assign win_addr = addr_arr[grant_idx];
  assign win_data = data_arr[grant_idx];

  always_comb begin
    state_next      = state_reg;
    sweep_cnt_next  = sweep_cnt_reg;
    last_grant_next = last_grant_reg;
    wr_enable_next  = 1'b0;
    wr_addr_next    = wr_addr_reg;
    wr_data_next    = wr_data_reg;

    unique case (state_reg)
      ST_INIT: begin
        // Address 0 is written too: the sweep must clear it regardless of
        // whether later writes to it are dropped.
        wr_enable_next = 1'b1;
        wr_addr_next   = sweep_cnt_reg;
        wr_data_next   = '0;
        if (sweep_cnt_reg == LAST_SET) begin
          state_next = ST_ARB;
        end else begin
          sweep_cnt_next = sweep_cnt_reg + AW'(1);
        end
      end

      ST_ARB: begin
        if (grant_active) begin
          // A write to address 0 still completes its handshake and still
          // rotates priority; only the enable is suppressed.
          wr_addr_next    = win_addr;
          wr_data_next    = win_data;
          last_grant_next = grant_idx;
          wr_enable_next  = !(PROTECT_0 && (win_addr == '0));
        end
      end

      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= ST_INIT;
      sweep_cnt_reg  <= '0;
      last_grant_reg <= LAST_REQ;
      wr_enable_reg  <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      sweep_cnt_reg  <= sweep_cnt_next;
      last_grant_reg <= last_grant_next;
      wr_enable_reg  <= wr_enable_next;
      wr_addr_reg    <= wr_addr_next;
      wr_data_reg    <= wr_data_next;
    end
  end

  assign init_busy    = (state_reg == ST_INIT);
  assign rf_wr_enable = wr_enable_reg;
  assign rf_wr_addr   = wr_addr_reg;
  assign rf_wr_data   = wr_data_reg;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wr_arbiter
//
// Purpose:
//   Directed bench for regfile_wr_arbiter (2 requesters, 32 entries, 32-bit
//   data, x0 protected). A behavioural model predicts every output each
//   cycle; directed scenarios add hand-computed literal expectations. A
//   shadow register file built from the DUT write port is compared against
//   the model's own file at the end.
// ---------------------------------------------------------------------------
module tb_regfile_wr_arbiter;

  localparam int NR = 2;
  localparam int NS = 32;
  localparam int DW = 32;
  localparam int AW = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*AW-1:0]  req_addr  = '0;
  logic [NR*DW-1:0]  req_data  = '0;
  logic [NR-1:0]     req_ready;
  logic              init_busy;
  logic              rf_wr_enable;
  logic [AW-1:0]     rf_wr_addr;
  logic [DW-1:0]     rf_wr_data;

  regfile_wr_arbiter #(
    .NUM_REQ          (NR),
    .NUM_OF_SETS      (NS),
    .DATA_BUS_WIDTH   (DW),
    .ZERO_REG_PROTECT (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .init_busy    (init_busy),
    .rf_wr_enable (rf_wr_enable),
    .rf_wr_addr   (rf_wr_addr),
    .rf_wr_data   (rf_wr_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model
  // -------------------------------------------------------------------------
  bit            model_ok = 1'b0;
  bit            m_init;
  int            m_sweep;
  int            m_last;
  bit            m_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [DW-1:0] ref_rf [NS];
  logic [DW-1:0] dut_rf [NS];

  // Round-robin pick: first valid requester after the last one served.
  function automatic int m_winner();
    if (m_init) return -1;
    for (int k = 1; k <= NR; k++) begin
      int i;
      i = (m_last + k) % NR;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int w;
    w = m_winner();
    // Register-file contents: a write visible in a cycle lands at its end.
    if (model_ok && rf_wr_enable) dut_rf[rf_wr_addr] = rf_wr_data;
    if (model_ok && m_en) ref_rf[m_addr] = m_data;
    if (!rst) begin
      model_ok = 1'b1;
      m_init   = 1'b1;
      m_sweep  = 0;
      m_last   = NR - 1;
      m_en     = 1'b0;
      m_addr   = '0;
      m_data   = '0;
    end else if (model_ok) begin
      if (m_init) begin
        m_en   = 1'b1;
        m_addr = AW'(m_sweep);
        m_data = '0;
        if (m_sweep == NS - 1) m_init = 1'b0;
        else m_sweep++;
      end else if (w >= 0) begin
        m_addr = req_addr[w*AW +: AW];
        m_data = req_data[w*DW +: DW];
        m_last = w;
        m_en   = (m_addr != 0);
      end else begin
        m_en = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : compare
    int w;
    logic [NR-1:0] exp_ready;
    if (model_ok) begin
      w = m_winner();
      exp_ready = '0;
      if (w >= 0) exp_ready[w] = 1'b1;
      check("cmp_ready", req_ready, exp_ready);
      check("cmp_busy", init_busy, m_init);
      check("cmp_en", rf_wr_enable, m_en);
      check("cmp_addr", rf_wr_addr, m_addr);
      check("cmp_data", rf_wr_data, m_data);
    end
  end

  task automatic drive(input logic [NR-1:0] v, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req_valid = v;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
  endtask

  // -------------------------------------------------------------------------
  // Directed scenarios
  // -------------------------------------------------------------------------
  initial begin
    // T1: reset two cycles, then the zero sweep
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("t1_reset_busy", init_busy, 1'b1);
    check("t1_reset_en", rf_wr_enable, 1'b0);
    check("t1_reset_ready", req_ready, 2'b00);
    for (int c = 0; c < NS; c++) begin
      @(negedge clk);
      check("t1_sweep_en", rf_wr_enable, 1'b1);
      check("t1_sweep_addr", rf_wr_addr, c);
      check("t1_sweep_data", rf_wr_data, 0);
      check("t1_sweep_busy", init_busy, (c < NS - 1));
    end
    $display("T1 sweep of %0d writes done", NS);

    // T3: both requesters valid for 6 cycles -> 0,1,0,1,0,1 back to back
    @(posedge clk); #1 drive(2'b11, 5'd1, 32'h100, 5'd2, 32'h200);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t3_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) begin
        check("t3_en", rf_wr_enable, 1'b1);
        check("t3_addr", rf_wr_addr, ((k - 1) % 2 == 0) ? 5'd1 : 5'd2);
      end
      $display("T3 cycle %0d ready=%b", k, req_ready);
    end
    @(posedge clk); #1 drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    @(negedge clk);
    check("t3_last_en", rf_wr_enable, 1'b1);
    check("t3_last_addr", rf_wr_addr, 5'd2);
    check("t3_last_data", rf_wr_data, 32'h200);

    // T2: single write from requester 0
    @(posedge clk); #1 drive(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
    @(negedge clk);
    check("t2_ready", req_ready, 2'b01);
    @(posedge clk); #1 drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    @(negedge clk);
    check("t2_en", rf_wr_enable, 1'b1);
    check("t2_addr", rf_wr_addr, 5'd5);
    check("t2_data", rf_wr_data, 32'hDEADBEEF);
    $display("T2 write addr=%0d data=%h", rf_wr_addr, rf_wr_data);

    // T4: requester 1 writes x0 -> handshake but no enable
    @(posedge clk); #1 drive(2'b10, 5'd9, 32'h0, 5'd0, 32'h1234);
    @(negedge clk);
    check("t4_ready", req_ready, 2'b10);
    @(posedge clk); #1 drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    @(negedge clk);
    check("t4_en_dropped", rf_wr_enable, 1'b0);
    @(negedge clk);
    check("t4_x0_zero", dut_rf[0], 32'h0);
    check("t2_rf5", dut_rf[5], 32'hDEADBEEF);
    check("t3_rf2", dut_rf[2], 32'h200);
    $display("T4 x0 write dropped, rf[0]=%h", dut_rf[0]);
    // the dropped write still rotated priority to requester 0
    @(posedge clk); #1 drive(2'b11, 5'd3, 32'h33, 5'd4, 32'h44);
    @(negedge clk);
    check("t4_rotation", req_ready, 2'b01);

    // T6: reset while requester 1 is being granted
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t6_pre_ready", req_ready, 2'b10);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("t6_no_write", rf_wr_enable, 1'b0);
    check("t6_busy", init_busy, 1'b1);
    check("t6_ready", req_ready, 2'b00);

    // T5: requests held through the restarted sweep
    for (int c = 0; c < NS; c++) begin
      @(negedge clk);
      check("t5_sweep_addr", rf_wr_addr, c);
      check("t5_ready", req_ready, (c == NS - 1) ? 2'b01 : 2'b00);
    end
    $display("T5/T6 sweep restarted, first ARB grant ready=%b", req_ready);
    @(negedge clk);
    check("t5_first_write", rf_wr_addr, 5'd3);
    check("t5_next_grant", req_ready, 2'b10);
    @(posedge clk); #1 drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    repeat (3) @(negedge clk);

    for (int i = 0; i < NS; i++) begin
      check("rf_contents", dut_rf[i], ref_rf[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
